// File: rtl/prng_rnd_buffer.sv
// Randomness FIFO between prng_top and the masked AES core: each word is delivered
// exactly once, consumed and flushed slots are zeroized, starved cycles are counted.
module prng_rnd_buffer #(
  parameter int RND   = 2040,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [RND-1:0]           in_rnd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [RND-1:0]           out_rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNTW-1:0]          starve_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [RND-1:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CNTW-1:0] starve_q, starve_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            push_s, pop_s;

  // Next-state: handshake qualification, pointers, level and starvation counter.
  always_comb begin
    push_s      = in_valid & in_ready_q;
    pop_s       = out_valid_q & out_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    starve_d    = starve_q;
    if (out_ready && !out_valid_q && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_s};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_s};
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
        default: level_d = level_q;
      endcase
    end
    // Handshake flags are registered from the next level, so out_ready never
    // reaches in_ready combinationally.
    in_ready_d  = (level_d != FULL_LVL);
    out_valid_d = (level_d != {LW{1'b0}});
  end

  // State registers; rst and flush both zeroize storage, only rst clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      starve_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      starve_q    <= starve_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          mem_q[i] <= '0;
        end else if (pop_s && (rd_ptr_q == AW'(i))) begin
          mem_q[i] <= '0;
        end else if (push_s && (wr_ptr_q == AW'(i))) begin
          mem_q[i] <= in_rnd;
        end else begin
          mem_q[i] <= mem_q[i];
        end
      end
    end
  end

  // Output view of the head slot, forced to zero while nothing is buffered.
  always_comb begin
    out_rnd = '0;
    if (out_valid_q) begin
      out_rnd = mem_q[rd_ptr_q];
    end else begin
      out_rnd = '0;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_prng_rnd_buffer.sv
// Scoreboard bench for prng_rnd_buffer: a queue model tracks accepted words, a
// negedge monitor checks every delivered word, level, flags and the starvation count.
module tb_prng_rnd_buffer;

  localparam int RND   = 2040;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [RND-1:0]  in_rnd;
  logic            in_ready, out_valid;
  logic [RND-1:0]  out_rnd;
  logic [LW-1:0]   level;
  logic [CNTW-1:0] starve_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RND-1:0] exp_q[$];
  int             st_model = 0;

  prng_rnd_buffer #(.RND(RND), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_rnd     (in_rnd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_rnd    (out_rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RND-1:0] rnd_word();
    logic [RND-1:0] w = '0;
    for (int i = 0; i < (RND + 31) / 32; i++) begin
      w = {w[RND-33:0], 32'($urandom())};
    end
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem_zero(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      check(nm, dut.mem_q[i] == '0, dut.mem_q[i][63:0], 64'd0);
    end
  endtask

  // Monitor: compare DUT against the queue model, then advance the model for the coming edge.
  always @(negedge clk) begin
    check("level", int'(level) == exp_q.size(), 64'(level), 64'(exp_q.size()));
    check("out_valid", out_valid == (exp_q.size() != 0), 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_ready", in_ready == (exp_q.size() != DEPTH), 64'(in_ready), 64'(exp_q.size() != DEPTH));
    check("starve_cnt", int'(starve_cnt) == st_model, 64'(starve_cnt), 64'(st_model));
    if (!out_valid) begin
      check("out_rnd_idle_zero", out_rnd == '0, out_rnd[63:0], 64'd0);
    end
    if (rst) begin
      exp_q.delete();
      st_model = 0;
    end else begin
      if (out_ready && !out_valid && st_model < CMAX) st_model++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("pop_underflow", 1'b0, out_rnd[63:0], 64'd0);
          end else begin
            check("out_rnd", out_rnd == exp_q[0], out_rnd[63:0], exp_q[0][63:0]);
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_rnd);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_rnd = rnd_word();
    cyc(); cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_level", level == '0, 64'(level), 64'd0);
    check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
    check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check("rst_out_rnd", out_rnd == '0, out_rnd[63:0], 64'd0);
    cyc();

    // Fill then drain in order.
    for (int k = 1; k <= DEPTH; k++) begin
      in_valid = 1'b1; in_rnd = RND'(k);
      cyc();
    end
    in_valid = 1'b0;
    check("fill_level", int'(level) == DEPTH, 64'(level), 64'(DEPTH));
    check("fill_in_ready", in_ready == 1'b0, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    repeat (DEPTH) cyc();
    out_ready = 1'b0;
    check("drain_level", level == '0, 64'(level), 64'd0);
    check_mem_zero("drain_mem_zero");
    check("drain_out_rnd", out_rnd == '0, out_rnd[63:0], 64'd0);

    // Continuous stream across pointer wrap.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_rnd = rnd_word();
      cyc();
      check("stream_level", int'(level) == 1, 64'(level), 64'd1);
    end
    in_valid = 1'b0;
    cyc(); cyc();
    out_ready = 1'b0;

    // Flush wins over a simultaneous push and pop.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_rnd = rnd_word();
      cyc();
    end
    check("pre_flush_level", int'(level) == 3, 64'(level), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_rnd = rnd_word();
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_level", level == '0, 64'(level), 64'd0);
    check("flush_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check_mem_zero("flush_mem_zero");

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_rnd    = rnd_word();
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH && out_valid; k++) cyc();
    check("rand_drained", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check_mem_zero("rand_mem_zero");

    // Starvation counter saturates, survives flush, clears on rst.
    repeat (CMAX + 40) cyc();
    check("starve_sat", int'(starve_cnt) == CMAX, 64'(starve_cnt), 64'(CMAX));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("starve_after_flush", int'(starve_cnt) == CMAX, 64'(starve_cnt), 64'(CMAX));
    out_ready = 1'b0; rst = 1'b1; in_valid = 1'b1; in_rnd = rnd_word();
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("starve_after_rst", starve_cnt == '0, 64'(starve_cnt), 64'd0);
    check("rst_no_capture", level == '0, 64'(level), 64'd0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
